// File: rtl/aes1_seq_pkg.sv
// aes1_seq_pkg: shared constants and types for the AES1 block sequencer.
//   - AES1 wrapper register byte addresses (12-bit byte address space)
//   - CTRL / STATUS bit positions and CTRL write values
//   - sequencer state enum and a poll-state helper
package aes1_seq_pkg;

    localparam logic [11:0] ADDR_CTRL    = 12'h040;
    localparam logic [11:0] ADDR_STATUS  = 12'h048;
    localparam logic [11:0] ADDR_ENCDEC  = 12'h050;
    localparam logic [11:0] ADDR_KEY_SEL = 12'h070;
    localparam logic [11:0] ADDR_BLOCK0  = 12'h200;
    localparam logic [11:0] ADDR_RESULT0 = 12'h280;

    localparam int CTRL_INIT_BIT    = 0;
    localparam int CTRL_NEXT_BIT    = 1;
    localparam int STATUS_READY_BIT = 0;
    localparam int STATUS_VALID_BIT = 1;

    localparam logic [63:0] CTRL_INIT_VAL = 64'(1) << CTRL_INIT_BIT;
    localparam logic [63:0] CTRL_NEXT_VAL = 64'(1) << CTRL_NEXT_BIT;

    typedef enum logic [3:0] {
        IDLE, SEL, MODE, INIT_SET, INIT_CLR, INIT_WAIT, WAIT_IN, WR_BLK,
        NEXT_SET, NEXT_CLR, POLL_BUSY, POLL_DONE, RD_RES, OUT, ERR
    } state_e;

    function automatic logic is_poll(state_e s);
        return (s == INIT_WAIT) || (s == POLL_BUSY) || (s == POLL_DONE);
    endfunction

endpackage

// File: rtl/aes1_seq_poll_timer.sv
// aes1_seq_poll_timer: poll-state watchdog counter.
//   clk_i, rst_i : clock, synchronous active-high reset
//   load_i       : restart the count from zero (state entry)
//   en_i         : count one more poll cycle
//   expired_o    : current cycle is the LIMIT-th poll cycle since load
module aes1_seq_poll_timer #(
    parameter int LIMIT = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || load_i) begin
            cnt_q <= '0;
        end else if (en_i && !expired_o) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // cnt_q holds the number of completed poll cycles, so it equals LIMIT-1
    // during the LIMIT-th one.
    assign expired_o = (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/aes1_block_sequencer.sv
// aes1_block_sequencer: register-bus master that configures the AES1 wrapper
// and streams 128-bit blocks through it (write block, pulse next, poll, read).
//   clk_i, rst_i           : clock, synchronous active-high reset
//   cfg_start_i            : start pulse; latches cfg_encdec_i / cfg_key_sel_i
//   in_valid_i/in_ready_o  : input block stream (in_block_i, in_last_i)
//   out_valid_o/out_ready_i: result stream (out_block_o, out_last_o)
//   reg_*                  : one-access-per-cycle register port to the wrapper
//   busy_o                 : not IDLE and not ERR
//   err_timeout_o          : sticky poll timeout, cleared by cfg_start_i
// Optional macro AES1_SEQ_PERF_CNT_EN adds perf_blocks_o / perf_stall_o.
module aes1_block_sequencer
    import aes1_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int ADDR_W         = 12
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cfg_start_i,
    input  logic              cfg_encdec_i,
    input  logic [1:0]        cfg_key_sel_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [127:0]      in_block_i,
    input  logic              in_last_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [127:0]      out_block_o,
    output logic              out_last_o,
    output logic [ADDR_W-1:0] reg_addr_o,
    output logic              reg_en_o,
    output logic              reg_we_o,
    output logic [63:0]       reg_wdata_o,
    input  logic [63:0]       reg_rdata_i,
    output logic              busy_o,
`ifdef AES1_SEQ_PERF_CNT_EN
    output logic [31:0]       perf_blocks_o,
    output logic [31:0]       perf_stall_o,
`endif
    output logic              err_timeout_o
);
    state_e             state_q, state_d;
    logic [1:0]         wcnt_q, wcnt_d;
    logic               encdec_q, encdec_d;
    logic [1:0]         key_sel_q, key_sel_d;
    logic [127:0]       blk_q, blk_d;
    logic               last_q, last_d;
    logic [127:0]       res_q, res_d;
    logic               err_q, err_d;
    logic               reg_en_q, reg_en_d, reg_we_q, reg_we_d;
    logic [ADDR_W-1:0]  reg_addr_q, reg_addr_d;
    logic [11:0]        addr12_d;
    logic [63:0]        reg_wdata_q, reg_wdata_d;
    logic               in_ready_q, out_valid_q, busy_q;
    logic               tmr_load, tmr_en, tmr_expired;
    logic               unused_rdata_hi;

    assign unused_rdata_hi = ^reg_rdata_i[63:32];

    // Next-state logic; reg_rdata_i is only meaningful in the poll/read
    // states, where the registered reg_en_o is high for the same cycle.
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        encdec_d  = encdec_q;
        key_sel_d = key_sel_q;
        blk_d     = blk_q;
        last_d    = last_q;
        res_d     = res_q;
        err_d     = err_q;
        case (state_q)
            IDLE, ERR: if (cfg_start_i) begin
                encdec_d  = cfg_encdec_i;
                key_sel_d = cfg_key_sel_i;
                err_d     = 1'b0;
                state_d   = SEL;
            end
            SEL:      state_d = MODE;
            MODE:     state_d = INIT_SET;
            INIT_SET: state_d = INIT_CLR;
            INIT_CLR: state_d = INIT_WAIT;
            INIT_WAIT: begin
                if (reg_rdata_i[STATUS_READY_BIT]) state_d = WAIT_IN;
                else if (tmr_expired) begin err_d = 1'b1; state_d = ERR; end
            end
            WAIT_IN: if (in_valid_i) begin
                blk_d   = in_block_i;
                last_d  = in_last_i;
                wcnt_d  = 2'd0;
                state_d = WR_BLK;
            end
            WR_BLK: begin
                wcnt_d = wcnt_q + 2'd1;
                if (wcnt_q == 2'd3) state_d = NEXT_SET;
            end
            NEXT_SET: state_d = NEXT_CLR;
            NEXT_CLR: state_d = POLL_BUSY;
            // Wait for ready to drop first so a valid left over from the
            // previous block is never mistaken for this block's result.
            POLL_BUSY: begin
                if (!reg_rdata_i[STATUS_READY_BIT]) state_d = POLL_DONE;
                else if (tmr_expired) begin err_d = 1'b1; state_d = ERR; end
            end
            POLL_DONE: begin
                if (reg_rdata_i[STATUS_READY_BIT] && reg_rdata_i[STATUS_VALID_BIT]) begin
                    wcnt_d  = 2'd0;
                    state_d = RD_RES;
                end else if (tmr_expired) begin
                    err_d   = 1'b1;
                    state_d = ERR;
                end
            end
            RD_RES: begin
                res_d[{wcnt_q, 5'd0} +: 32] = reg_rdata_i[31:0];
                wcnt_d = wcnt_q + 2'd1;
                if (wcnt_q == 2'd3) state_d = OUT;
            end
            OUT: if (out_ready_i) state_d = last_q ? IDLE : WAIT_IN;
            default: state_d = IDLE;
        endcase
    end

    // Bus access for the state being entered, so the port is registered.
    always_comb begin
        reg_en_d    = 1'b0;
        reg_we_d    = 1'b0;
        addr12_d    = '0;
        reg_wdata_d = '0;
        case (state_d)
            SEL:      begin reg_en_d = 1'b1; reg_we_d = 1'b1; addr12_d = ADDR_KEY_SEL; reg_wdata_d = {62'd0, key_sel_d}; end
            MODE:     begin reg_en_d = 1'b1; reg_we_d = 1'b1; addr12_d = ADDR_ENCDEC;  reg_wdata_d = {63'd0, encdec_d}; end
            INIT_SET: begin reg_en_d = 1'b1; reg_we_d = 1'b1; addr12_d = ADDR_CTRL;    reg_wdata_d = CTRL_INIT_VAL; end
            NEXT_SET: begin reg_en_d = 1'b1; reg_we_d = 1'b1; addr12_d = ADDR_CTRL;    reg_wdata_d = CTRL_NEXT_VAL; end
            INIT_CLR, NEXT_CLR: begin reg_en_d = 1'b1; reg_we_d = 1'b1; addr12_d = ADDR_CTRL; end
            INIT_WAIT, POLL_BUSY, POLL_DONE: begin reg_en_d = 1'b1; addr12_d = ADDR_STATUS; end
            WR_BLK: begin
                reg_en_d    = 1'b1;
                reg_we_d    = 1'b1;
                addr12_d    = ADDR_BLOCK0 | {7'd0, wcnt_d, 3'b000};
                reg_wdata_d = {32'd0, blk_d[{wcnt_d, 5'd0} +: 32]};
            end
            RD_RES: begin reg_en_d = 1'b1; addr12_d = ADDR_RESULT0 | {7'd0, wcnt_d, 3'b000}; end
            default: ;
        endcase
        reg_addr_d = ADDR_W'(addr12_d);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            wcnt_q      <= '0;
            encdec_q    <= 1'b0;
            key_sel_q   <= '0;
            blk_q       <= '0;
            last_q      <= 1'b0;
            res_q       <= '0;
            err_q       <= 1'b0;
            reg_en_q    <= 1'b0;
            reg_we_q    <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            encdec_q    <= encdec_d;
            key_sel_q   <= key_sel_d;
            blk_q       <= blk_d;
            last_q      <= last_d;
            res_q       <= res_d;
            err_q       <= err_d;
            reg_en_q    <= reg_en_d;
            reg_we_q    <= reg_we_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            in_ready_q  <= (state_d == WAIT_IN);
            out_valid_q <= (state_d == OUT);
            busy_q      <= !(state_d inside {IDLE, ERR});
        end
    end

    assign tmr_load = (state_d != state_q);
    assign tmr_en   = is_poll(state_q);

    aes1_seq_poll_timer #(.LIMIT(TIMEOUT_CYCLES)) u_poll_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (tmr_load),
        .en_i      (tmr_en),
        .expired_o (tmr_expired)
    );

    assign in_ready_o    = in_ready_q;
    assign out_valid_o   = out_valid_q;
    assign out_block_o   = res_q;
    assign out_last_o    = last_q;
    assign reg_addr_o    = reg_addr_q;
    assign reg_en_o      = reg_en_q;
    assign reg_we_o      = reg_we_q;
    assign reg_wdata_o   = reg_wdata_q;
    assign busy_o        = busy_q;
    assign err_timeout_o = err_q;

`ifdef AES1_SEQ_PERF_CNT_EN
    logic [31:0] perf_blocks_q, perf_stall_q;
    logic        start_acc;

    assign start_acc = cfg_start_i && (state_q inside {IDLE, ERR});

    always_ff @(posedge clk_i) begin
        if (rst_i || start_acc) begin
            perf_blocks_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            if (out_valid_q && out_ready_i && perf_blocks_q != '1)
                perf_blocks_q <= perf_blocks_q + 32'd1;
            if ((state_q inside {POLL_BUSY, POLL_DONE}) && perf_stall_q != '1)
                perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_blocks_o = perf_blocks_q;
    assign perf_stall_o  = perf_stall_q;
`endif

endmodule

// File: tb/tb_aes1_block_sequencer.sv
// Directed bench for aes1_block_sequencer with a behavioural AES1 wrapper
// stub: edge-detected CTRL, STATUS ready/valid with a few cycles of latency,
// the FIPS-197 AES-128 vector pair for key bank 0, and bitwise NOT as the
// stand-in transform for any other block. 'dead' makes the stub behave like
// a locked wrapper (writes dropped, all reads 0).
module tb_aes1_block_sequencer;
    localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B1 = 128'h00000001_00000002_00000003_00000004;
    localparam logic [127:0] E1 = 128'hfffffffe_fffffffd_fffffffc_fffffffb;
    localparam logic [127:0] B2 = 128'hdeadbeef_01234567_89abcdef_cafef00d;
    localparam logic [127:0] E2 = 128'h21524110_fedcba98_76543210_35010ff2;
    localparam logic [127:0] B3 = 128'h0;
    localparam logic [127:0] E3 = {128{1'b1}};

    logic         clk = 1'b0;
    logic         rst_i = 1'b1;
    logic         cfg_start_i = 1'b0, cfg_encdec_i = 1'b0;
    logic [1:0]   cfg_key_sel_i = 2'd0;
    logic         in_valid_i = 1'b0, in_last_i = 1'b0;
    logic [127:0] in_block_i = '0;
    logic         out_ready_i = 1'b0;
    logic         in_ready_o, out_valid_o, out_last_o, busy_o, err_timeout_o;
    logic [127:0] out_block_o;
    logic [11:0]  reg_addr_o;
    logic         reg_en_o, reg_we_o;
    logic [63:0]  reg_wdata_o, reg_rdata_i;
`ifdef AES1_SEQ_PERF_CNT_EN
    logic [31:0]  perf_blocks_o, perf_stall_o;
`endif

    always #5 clk = ~clk;

    aes1_block_sequencer #(.TIMEOUT_CYCLES(16), .ADDR_W(12)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .cfg_start_i(cfg_start_i), .cfg_encdec_i(cfg_encdec_i), .cfg_key_sel_i(cfg_key_sel_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_block_i(in_block_i), .in_last_i(in_last_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_block_o(out_block_o), .out_last_o(out_last_o),
        .reg_addr_o(reg_addr_o), .reg_en_o(reg_en_o), .reg_we_o(reg_we_o),
        .reg_wdata_o(reg_wdata_o), .reg_rdata_i(reg_rdata_i),
        .busy_o(busy_o),
`ifdef AES1_SEQ_PERF_CNT_EN
        .perf_blocks_o(perf_blocks_o), .perf_stall_o(perf_stall_o),
`endif
        .err_timeout_o(err_timeout_o)
    );

    // ---------------- wrapper stub ----------------
    logic             dead = 1'b0;
    logic [1:0]       s_ksel;
    logic             s_enc, s_ready, s_valid, s_next;
    logic [3:0][31:0] s_blk;
    logic [127:0]     s_res;
    logic [63:0]      s_ctrl;
    int               s_cnt;

    function automatic logic [127:0] core(input logic enc, input logic [1:0] ks, input logic [127:0] b);
        if (ks == 2'd0 && enc && b == PT) return CT;
        if (ks == 2'd0 && !enc && b == CT) return PT;
        return ~b;
    endfunction

    always @(posedge clk) begin
        if (rst_i) begin
            s_ksel <= 0; s_enc <= 0; s_ready <= 1; s_valid <= 0; s_next <= 0;
            s_blk <= '0; s_res <= '0; s_ctrl <= '0; s_cnt <= 0;
        end else begin
            if (s_cnt > 0) begin
                s_cnt <= s_cnt - 1;
                if (s_cnt == 1) begin
                    s_ready <= 1'b1;
                    if (s_next) begin s_valid <= 1'b1; s_res <= core(s_enc, s_ksel, s_blk); end
                end
            end
            if (reg_en_o && reg_we_o && !dead) begin
                case (reg_addr_o)
                    12'h070: s_ksel <= reg_wdata_o[1:0];
                    12'h050: s_enc  <= reg_wdata_o[0];
                    12'h200: s_blk[0] <= reg_wdata_o[31:0];
                    12'h208: s_blk[1] <= reg_wdata_o[31:0];
                    12'h210: s_blk[2] <= reg_wdata_o[31:0];
                    12'h218: s_blk[3] <= reg_wdata_o[31:0];
                    12'h040: begin
                        s_ctrl <= reg_wdata_o;
                        if (reg_wdata_o[0] && !s_ctrl[0]) begin s_ready <= 0; s_next <= 0; s_cnt <= 3; end
                        if (reg_wdata_o[1] && !s_ctrl[1]) begin s_ready <= 0; s_valid <= 0; s_next <= 1; s_cnt <= 5; end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        reg_rdata_i = '0;
        if (reg_en_o && !reg_we_o && !dead) begin
            case (reg_addr_o)
                12'h048: reg_rdata_i = {62'd0, s_valid, s_ready};
                12'h280: reg_rdata_i = {32'd0, s_res[31:0]};
                12'h288: reg_rdata_i = {32'd0, s_res[63:32]};
                12'h290: reg_rdata_i = {32'd0, s_res[95:64]};
                12'h298: reg_rdata_i = {32'd0, s_res[127:96]};
                default: ;
            endcase
        end
    end

    // ---------------- bus monitors ----------------
    int en_cnt = 0, ksel_wr = 0, ctrl_wr = 0, stat_rd = 0;
    always @(posedge clk) begin
        if (reg_en_o) begin
            en_cnt++;
            if (reg_we_o && reg_addr_o == 12'h070) ksel_wr++;
            if (reg_we_o && reg_addr_o == 12'h040) ctrl_wr++;
            if (!reg_we_o && reg_addr_o == 12'h048) stat_rd++;
        end
    end

    // ---------------- checking helpers ----------------
    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic start(input logic enc, input logic [1:0] ks);
        cfg_encdec_i = enc; cfg_key_sel_i = ks; cfg_start_i = 1'b1;
        step(1);
        cfg_start_i = 1'b0;
    endtask

    task automatic send(input logic [127:0] b, input logic l, input string tag);
        int n = 0;
        in_valid_i = 1'b1; in_block_i = b; in_last_i = l;
        while (in_ready_o !== 1'b1 && n < 200) begin step(1); n++; end
        chk({tag, "_in_wait"}, 128'(n < 200), 128'd1);
        step(1);
        in_valid_i = 1'b0;
    endtask

    task automatic recv(input logic [127:0] e, input logic el, input int stall, input string tag);
        int n = 0;
        out_ready_i = 1'b0;
        while (out_valid_o !== 1'b1 && n < 200) begin step(1); n++; end
        chk({tag, "_out_wait"}, 128'(n < 200), 128'd1);
        for (int i = 0; i < stall; i++) begin
            chk({tag, "_stall_blk"}, out_block_o, e);
            chk({tag, "_stall_vld_rdy"}, {out_valid_o, in_ready_o}, 2'b10);
            step(1);
        end
        chk({tag, "_blk"}, out_block_o, e);
        chk({tag, "_last"}, out_last_o, el);
        out_ready_i = 1'b1;
        step(1);
        out_ready_i = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k0, c0, e0, s0, n;

        // reset state
        step(2);
        chk("rst_ctl", {reg_en_o, reg_we_o, in_ready_o, out_valid_o, busy_o, err_timeout_o, out_last_o}, 7'd0);
        chk("rst_addr", reg_addr_o, 12'h0);
        chk("rst_wdata", reg_wdata_o, 64'h0);
        chk("rst_blk", out_block_o, 128'h0);
        rst_i = 1'b0;
        step(1);

        // encrypt FIPS-197 vector, key bank 0
        start(1'b1, 2'd0);
        chk("t1_sel_ctl", {reg_en_o, reg_we_o, busy_o}, 3'b111);
        chk("t1_sel_addr", reg_addr_o, 12'h070);
        chk("t1_sel_wd", reg_wdata_o, 64'd0);
        step(1);
        chk("t1_mode", {reg_addr_o, reg_wdata_o}, {12'h050, 64'd1});
        step(1);
        chk("t1_init_set", {reg_addr_o, reg_wdata_o}, {12'h040, 64'd1});
        step(1);
        chk("t1_init_clr", {reg_addr_o, reg_wdata_o}, {12'h040, 64'd0});
        send(PT, 1'b1, "t1");
        recv(CT, 1'b1, 0, "t1");
        chk("t1_idle", {busy_o, out_valid_o, in_ready_o}, 3'b000);

        // decrypt back
        start(1'b0, 2'd0);
        send(CT, 1'b1, "t2");
        recv(PT, 1'b1, 0, "t2");

        // three blocks, ignored restart while busy, stall on block 2
        k0 = ksel_wr;
        start(1'b1, 2'd1);
        step(2);
        cfg_key_sel_i = 2'd2; cfg_encdec_i = 1'b0; cfg_start_i = 1'b1;
        step(1);
        cfg_start_i = 1'b0;
        send(B1, 1'b0, "b1");
        recv(E1, 1'b0, 0, "b1");
        chk("t3_ksel_wr_cnt", 128'(ksel_wr - k0), 128'd1);
        chk("t3_stub_ksel_enc", {s_ksel, s_enc}, 3'b011);
        send(B2, 1'b0, "b2");
        recv(E2, 1'b0, 20, "b2");
        send(B3, 1'b1, "b3");
        recv(E3, 1'b1, 0, "b3");
        chk("t3_idle", busy_o, 1'b0);

        // reset during the third block-word write
        start(1'b1, 2'd0);
        in_valid_i = 1'b1; in_block_i = PT; in_last_i = 1'b1;
        n = 0;
        while (in_ready_o !== 1'b1 && n < 200) begin step(1); n++; end
        chk("t5_in_wait", 128'(n < 200), 128'd1);
        step(1);
        in_valid_i = 1'b0;
        chk("t5_w0", {reg_en_o, reg_we_o, reg_addr_o}, {2'b11, 12'h200});
        step(2);
        chk("t5_w2", {reg_en_o, reg_we_o, reg_addr_o, reg_wdata_o}, {2'b11, 12'h210, 64'h44556677});
        c0 = ctrl_wr;
        rst_i = 1'b1;
        step(1);
        chk("t5_rst_ctl", {reg_en_o, reg_we_o, in_ready_o, out_valid_o, busy_o, err_timeout_o, out_last_o}, 7'd0);
        chk("t5_rst_bus", {reg_addr_o, reg_wdata_o}, 76'd0);
        chk("t5_rst_blk", out_block_o, 128'h0);
        rst_i = 1'b0;
        e0 = en_cnt;
        step(10);
        chk("t5_no_bus", 128'(en_cnt - e0), 128'd0);
        chk("t5_no_ctrl", 128'(ctrl_wr - c0), 128'd0);

        // locked wrapper: STATUS reads 0 forever -> timeout
        dead = 1'b1;
        s0 = stat_rd;
        start(1'b1, 2'd0);
        n = 0;
        while (err_timeout_o !== 1'b1 && n < 100) begin step(1); n++; end
        chk("t6_err_wait", 128'(n < 100), 128'd1);
        chk("t6_stat_reads", 128'(stat_rd - s0), 128'd16);
        chk("t6_err_state", {err_timeout_o, busy_o, in_ready_o, reg_en_o}, 4'b1000);
        e0 = en_cnt;
        step(10);
        chk("t6_quiet", 128'(en_cnt - e0), 128'd0);
        chk("t6_sticky", err_timeout_o, 1'b1);
        dead = 1'b0;
        start(1'b1, 2'd0);
        chk("t6_restart", {err_timeout_o, reg_en_o, busy_o, reg_addr_o}, {3'b011, 12'h070});
        send(PT, 1'b1, "t6");
        recv(CT, 1'b1, 0, "t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
